// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: load/store over a req/gnt/rvalid data bus with a registered write-back triple.
// Optional build macro MISALIGN_TRAP_EN turns misaligned H/W accesses into faults instead of forcing alignment.
module memory_access_stage #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [DATA_W-1:0] alu_y_i,
  input  logic [DATA_W-1:0] rrd2_i,
  input  logic [4:0]        rd_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [DATA_W/8-1:0] dbus_be_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_regwe_o,
  output logic [4:0]        wb_regwa_o,
  output logic [DATA_W-1:0] wb_regwd_o,
  output logic              mem_fault_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              regwe_q;
  logic              trap_q;
  logic              ex_ready_q, dbus_req_q, dbus_we_q;
  logic [ADDR_W-1:0] dbus_addr_q;
  logic [DATA_W-1:0] dbus_wdata_q;
  logic [BE_W-1:0]   dbus_be_q;
  logic              wb_valid_q, wb_regwe_q, mem_fault_q;
  logic [4:0]        wb_regwa_q;
  logic [DATA_W-1:0] wb_regwd_q;

  logic              is_mem_c, trap_c;
  logic [1:0]        off_c;
  logic [DATA_W-1:0] wdata_c, shifted_c, load_c;
  logic [BE_W-1:0]   be_c;

  assign is_mem_c = mem_read_i | mem_write_i;

  // Store lane steering; the byte offset ignores address bits below the access size.
  always_comb begin
    off_c   = alu_y_i[1:0];
    wdata_c = rrd2_i;
    be_c    = '1;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_c = {BE_W{rrd2_i[7:0]}};
        be_c    = BE_W'(1) << alu_y_i[1:0];
      end
      2'b01: begin
        off_c   = {alu_y_i[1], 1'b0};
        wdata_c = {(BE_W/2){rrd2_i[15:0]}};
        be_c    = BE_W'(3) << {alu_y_i[1], 1'b0};
      end
      default: off_c = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   trap_c = 1'b0;
      2'b01:   trap_c = is_mem_c & alu_y_i[0];
      default: trap_c = is_mem_c & (|alu_y_i[1:0]);
    endcase
  end
`else
  assign trap_c = 1'b0;
`endif

  // Load extraction from the captured lane offset and access type.
  always_comb begin
    shifted_c = dbus_rdata_i >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   load_c = f3_q[2] ? DATA_W'(shifted_c[7:0])
                                : {{(DATA_W-8){shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   load_c = f3_q[2] ? DATA_W'(shifted_c[15:0])
                                : {{(DATA_W-16){shifted_c[15]}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      regwe_q      <= 1'b0;
      trap_q       <= 1'b0;
      ex_ready_q   <= 1'b1;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_wdata_q <= '0;
      dbus_be_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_regwe_q   <= 1'b0;
      wb_regwa_q   <= '0;
      wb_regwd_q   <= '0;
      mem_fault_q  <= 1'b0;
    end else begin
      wb_valid_q  <= 1'b0;
      mem_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid_i) begin
            ex_ready_q <= 1'b0;
            wb_regwa_q <= rd_i;
            f3_q       <= funct3_i;
            off_q      <= off_c;
            regwe_q    <= reg_write_i & (rd_i != 5'd0);
            trap_q     <= trap_c;
            if (trap_c) begin
              wb_regwe_q <= 1'b0;
              wb_regwd_q <= '0;
              state_q    <= WB;
            end else if (is_mem_c) begin
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= mem_write_i;
              dbus_addr_q  <= ADDR_W'(alu_y_i) & ~ADDR_W'(3);
              dbus_wdata_q <= wdata_c;
              dbus_be_q    <= mem_write_i ? be_c : '0;
              cnt_q        <= '0;
              state_q      <= REQ;
            end else begin
              wb_regwe_q <= reg_write_i & (rd_i != 5'd0);
              wb_regwd_q <= alu_y_i;
              state_q    <= WB;
            end
          end
        end
        REQ: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
          if (dbus_gnt_i) begin
            dbus_req_q <= 1'b0;
            if (dbus_we_q) begin
              wb_valid_q <= 1'b1;
              wb_regwe_q <= 1'b0;
              wb_regwd_q <= '0;
              state_q    <= WB;
            end else begin
              state_q <= RESP;
            end
          end else if (cnt_q >= CNT_LAST) begin
            dbus_req_q  <= 1'b0;
            wb_valid_q  <= 1'b1;
            mem_fault_q <= 1'b1;
            wb_regwe_q  <= 1'b0;
            wb_regwd_q  <= '0;
            state_q     <= WB;
          end
        end
        RESP: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
          if (dbus_rvalid_i) begin
            wb_valid_q <= 1'b1;
            wb_regwe_q <= regwe_q;
            wb_regwd_q <= load_c;
            state_q    <= WB;
          end else if (cnt_q >= CNT_LAST) begin
            wb_valid_q  <= 1'b1;
            mem_fault_q <= 1'b1;
            wb_regwe_q  <= 1'b0;
            wb_regwd_q  <= '0;
            state_q     <= WB;
          end
        end
        WB: begin
          // Bus completions raise the pulse on entry; ALU results and traps raise it here.
          if (!wb_valid_q) begin
            wb_valid_q  <= 1'b1;
            mem_fault_q <= trap_q;
          end else begin
            ex_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready_o   = ex_ready_q;
  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_wdata_o = dbus_wdata_q;
  assign dbus_be_o    = dbus_be_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_regwe_o   = wb_regwe_q;
  assign wb_regwa_o   = wb_regwa_q;
  assign wb_regwd_o   = wb_regwd_q;
  assign mem_fault_o  = mem_fault_q;

endmodule
